// File: rtl/fifo_enq_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_enq_arbiter_if
// Bundles the producer-side request handshake and the shared fifo_queue
// enqueue port that fifo_enq_arbiter sits between.
//
//   req_valid [NUM_REQ]        per-producer beat valid
//   req_last  [NUM_REQ]        beat closes its burst (1 = single beat or burst end)
//   req_data  [NUM_REQ*WIDTH]  payload; producer i at [i*WIDTH +: WIDTH]
//   req_ready [NUM_REQ]        beat accepted when valid & ready
//   fifo_full                  full flag from fifo_queue
//   fifo_enq                   enqueue strobe to fifo_queue
//   fifo_d_in [WIDTH+ID_W]     {producer id, payload} written into the queue
//
// Modports:
//   master - producers + queue side (drives requests and full)
//   slave  - the arbiter (drives ready, enq and d_in)
// ---------------------------------------------------------------------------
interface fifo_enq_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_enq;
  logic [WIDTH+ID_W-1:0]    fifo_d_in;

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_enq, fifo_d_in
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_enq, fifo_d_in
  );
endinterface

// File: rtl/fifo_enq_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_enq_arbiter
// Round-robin arbiter sharing one fifo_queue enqueue port among NUM_REQ
// producers. A producer that is granted a beat without req_last is locked in
// until it delivers its last beat. Every enqueued entry carries the producer
// id in its upper ID_W bits. Arbitration is combinational: the winning beat
// is written into the queue at the same rising edge it is accepted.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset; forces ready/enq/d_in low
//   bus   slave modport of fifo_enq_arbiter_if (request + enqueue signals)
//   perf_grant_cnt out  accepted beats per producer, producer i at
//                       [i*CNT_W +: CNT_W]        (FIFO_ARB_PERF_EN only)
//   perf_stall_cnt out  cycles with any valid blocked by fifo_full
//                                                  (FIFO_ARB_PERF_EN only)
//
// Build option: define FIFO_ARB_PERF_EN to add the saturating performance
// counters and their ports. Without it the arbiter behaves identically and
// CNT_W is unused.
// ---------------------------------------------------------------------------
module fifo_enq_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  fifo_enq_arbiter_if.slave        bus
`ifdef FIFO_ARB_PERF_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] perf_grant_cnt,
  output logic [CNT_W-1:0]         perf_stall_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {ARB, LOCK} st_t;

  st_t             st;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner;

  // Explicit wrap so non-power-of-two NUM_REQ never lands on an unused id.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) return '0;
    else                          return id + ID_W'(1);
  endfunction

  logic [ID_W-1:0]  arb_id;
  logic             arb_vld;
  logic [ID_W-1:0]  scan_id;
  logic [ID_W-1:0]  sel_id;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             ready_on;
  logic             xfer;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    arb_vld = 1'b0;
    arb_id  = rr_ptr;
    scan_id = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_vld && bus.req_valid[scan_id]) begin
        arb_vld = 1'b1;
        arb_id  = scan_id;
      end
      scan_id = next_id(scan_id);
    end
  end

  // In LOCK the owner holds the port whether or not it is presenting a beat,
  // so its ready tracks only fifo_full and every other producer is held off.
  always_comb begin
    sel_id    = (st == LOCK) ? owner : arb_id;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == sel_id) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
    ready_on = !rst && !bus.fifo_full && ((st == LOCK) || arb_vld);
    xfer     = ready_on && sel_valid;
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready_on && (ID_W'(i) == sel_id)) bus.req_ready[i] = 1'b1;
    end
    bus.fifo_enq  = xfer;
    bus.fifo_d_in = xfer ? {sel_id, sel_data} : '0;
  end

  // ---- state register: grant decision commits at the accepting edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ARB;
      rr_ptr <= '0;
      owner  <= '0;
    end else if (xfer) begin
      if (st == ARB) begin
        if (sel_last) begin
          rr_ptr <= next_id(sel_id);
        end else begin
          st    <= LOCK;
          owner <= sel_id;
        end
      end else if (sel_last) begin
        st     <= ARB;
        rr_ptr <= next_id(owner);
      end
    end
  end

`ifdef FIFO_ARB_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    else    return c + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] grant_cnt [NUM_REQ];
  logic [CNT_W-1:0] stall_cnt;

  // ---- perf counter register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && (ID_W'(i) == sel_id)) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
      if ((|bus.req_valid) && bus.fifo_full) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_comb begin
    perf_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) perf_grant_cnt[i*CNT_W +: CNT_W] = grant_cnt[i];
    perf_stall_cnt = stall_cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_enq_arbiter
// Directed scenarios plus a randomized run, all checked against a behavioural
// model of the round-robin/burst-lock rules. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_enq_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = $clog2(N);
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_enq_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

`ifdef FIFO_ARB_PERF_EN
  logic [N*CW-1:0] perf_g;
  logic [CW-1:0]   perf_s;
  fifo_enq_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .perf_grant_cnt(perf_g), .perf_stall_cnt(perf_s));

  // Narrow-counter copy fed the same inputs, for saturation.
  fifo_enq_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus2 ();
  assign bus2.req_valid = bus.req_valid;
  assign bus2.req_last  = bus.req_last;
  assign bus2.req_data  = bus.req_data;
  assign bus2.fifo_full = bus.fifo_full;
  logic [N*2-1:0] perf_g2;
  logic [1:0]     perf_s2;
  fifo_enq_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave),
    .perf_grant_cnt(perf_g2), .perf_stall_cnt(perf_s2));
`else
  fifo_enq_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: locked owner (or free) and next-priority producer.
  bit m_lock  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_g [N];
  int m_s     = 0;
  int m_g2 [N];
  int m_s2    = 0;

  logic [N-1:0]     e_ready, o_ready;
  logic             e_enq, o_enq;
  logic [W+IDW-1:0] e_din, o_din;

  // Drives one cycle, samples DUT outputs, forms expectations, advances model.
  task automatic apply(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic f, input logic [N*W-1:0] d);
    int g;
    bit xf;
    rst = r;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.fifo_full = f;
    bus.req_data  = d;
    @(negedge clk);
    o_ready = bus.req_ready;
    o_enq   = bus.fifo_enq;
    o_din   = bus.fifo_d_in;
    e_ready = '0;
    e_enq   = 1'b0;
    e_din   = '0;
    g  = -1;
    xf = 1'b0;
    if (!r) begin
      if (m_lock) begin
        g = m_owner;
        if (!f) e_ready[g] = 1'b1;
        xf = v[g] && !f;
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (g < 0 && v[idx]) g = idx;
        end
        if (g >= 0 && !f) e_ready[g] = 1'b1;
        xf = (g >= 0) && !f;
      end
      if (xf) begin
        e_enq = 1'b1;
        e_din = {IDW'(g), d[g*W +: W]};
      end
    end
    @(posedge clk);
    if (r) begin
      m_lock = 1'b0; m_owner = 0; m_ptr = 0; m_s = 0; m_s2 = 0;
      for (int i = 0; i < N; i++) begin m_g[i] = 0; m_g2[i] = 0; end
    end else begin
      if (xf) begin
        if (m_g[g] < (1 << CW) - 1) m_g[g]++;
        if (m_g2[g] < 3) m_g2[g]++;
        if (l[g]) begin
          m_lock = 1'b0;
          m_ptr  = (g + 1) % N;
        end else begin
          m_lock  = 1'b1;
          m_owner = g;
        end
      end
      if ((|v) && f) begin
        if (m_s < (1 << CW) - 1) m_s++;
        if (m_s2 < 3) m_s2++;
      end
    end
    #1;
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), rand_data());
      checks++;
      if ({o_ready, o_enq, o_din} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: ready=%b enq=%b din=%h, required all zero",
                 c, o_ready, o_enq, o_din);
      end
    end
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) begin
      apply(1'b0, 4'b1111, 4'b1111, 1'b0, rand_data());
      checks++;
      if ({o_ready, o_enq, o_din} !== {e_ready, e_enq, e_din}) begin
        errors++;
        $display("FAIL rr_model cyc %0d: ready=%b enq=%b din=%h, required ready=%b enq=%b din=%h",
                 c, o_ready, o_enq, o_din, e_ready, e_enq, e_din);
      end
      checks++;
      if (o_ready !== (4'b0001 << (c % 4)) || o_din[W +: IDW] !== IDW'(c % 4) || o_enq !== 1'b1) begin
        errors++;
        $display("FAIL rr_order cyc %0d: ready=%b tag=%0d enq=%b, required grant %0d",
                 c, o_ready, o_din[W +: IDW], o_enq, c % 4);
      end
    end
  endtask

  task automatic test_full_stall();
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 4'b0101, 4'b1111, 1'b1, rand_data());
      checks++;
      if ({o_ready, o_enq} !== '0 || {o_ready, o_enq, o_din} !== {e_ready, e_enq, e_din}) begin
        errors++;
        $display("FAIL full_block cyc %0d: ready=%b enq=%b din=%h, required ready=0 enq=0",
                 c, o_ready, o_enq, o_din);
      end
    end
`ifdef FIFO_ARB_PERF_EN
    checks++;
    if (perf_g !== {CW'(2), CW'(2), CW'(2), CW'(2)} || perf_s !== CW'(4)) begin
      errors++;
      $display("FAIL perf_after_stall: grant=%h stall=%0d, required 2 each and stall 4", perf_g, perf_s);
    end
    checks++;
    if (perf_g2 !== 8'b10_10_10_10 || perf_s2 !== 2'd3) begin
      errors++;
      $display("FAIL perf_sat_stall: grant=%b stall=%0d, required 2 each and stall 3", perf_g2, perf_s2);
    end
`endif
    apply(1'b0, 4'b0101, 4'b1111, 1'b0, rand_data());
    checks++;
    if (o_ready !== 4'b0001 || {o_ready, o_enq, o_din} !== {e_ready, e_enq, e_din}) begin
      errors++;
      $display("FAIL full_release: ready=%b enq=%b din=%h, required ready=%b din=%h",
               o_ready, o_enq, o_din, e_ready, e_din);
    end
  endtask

  task automatic test_burst();
    logic [N-1:0] v [4] = '{4'b0100, 4'b1111, 4'b1111, 4'b1111};
    logic [N-1:0] l [4] = '{4'b0000, 4'b0000, 4'b0100, 4'b1111};
    logic [N-1:0] r [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000};
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, v[c], l[c], 1'b0, rand_data());
      checks++;
      if (o_ready !== r[c] || {o_ready, o_enq, o_din} !== {e_ready, e_enq, e_din}) begin
        errors++;
        $display("FAIL burst beat %0d: ready=%b enq=%b din=%h, required ready=%b din=%h",
                 c, o_ready, o_enq, o_din, r[c], e_din);
      end
    end
  endtask

  task automatic test_wrap();
    logic [N*W-1:0] d;
    d = rand_data();
    d[3*W +: W] = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 4'b1000, 4'b1000, 1'b0, d);
      checks++;
      if (o_ready !== 4'b1000 || o_din !== {2'd3, 32'hDEADBEEF} || o_enq !== 1'b1) begin
        errors++;
        $display("FAIL wrap_single %0d: ready=%b enq=%b din=%h, required ready=1000 din=3_deadbeef",
                 c, o_ready, o_enq, o_din);
      end
    end
    apply(1'b0, 4'b1111, 4'b1111, 1'b0, rand_data());
    checks++;
    if (o_ready !== 4'b0001 || {o_ready, o_enq, o_din} !== {e_ready, e_enq, e_din}) begin
      errors++;
      $display("FAIL wrap_next: ready=%b, required ready=%b", o_ready, e_ready);
    end
  endtask

  task automatic test_lock_idle();
    apply(1'b0, 4'b0010, 4'b0000, 1'b0, rand_data());
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 4'b1101, 4'b1111, 1'b0, rand_data());
      checks++;
      if (o_ready !== 4'b0010 || o_enq !== 1'b0 || {o_ready, o_enq, o_din} !== {e_ready, e_enq, e_din}) begin
        errors++;
        $display("FAIL lock_idle %0d: ready=%b enq=%b, required ready=0010 enq=0", c, o_ready, o_enq);
      end
    end
    apply(1'b0, 4'b1111, 4'b0010, 1'b0, rand_data());
    apply(1'b0, 4'b1111, 4'b1111, 1'b0, rand_data());
    checks++;
    if (o_ready !== 4'b0100 || {o_ready, o_enq, o_din} !== {e_ready, e_enq, e_din}) begin
      errors++;
      $display("FAIL lock_release: ready=%b, required ready=0100", o_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply(1'b0, 4'b0010, 4'b0000, 1'b0, rand_data());
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 4'b1111, 4'b0000, 1'b0, rand_data());
      checks++;
      if ({o_ready, o_enq, o_din} !== '0) begin
        errors++;
        $display("FAIL rst_mid_burst %0d: ready=%b enq=%b din=%h, required all zero",
                 c, o_ready, o_enq, o_din);
      end
    end
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 4'b1111, 4'b1111, 1'b0, rand_data());
      checks++;
      if (o_ready !== (4'b0001 << c) || {o_ready, o_enq, o_din} !== {e_ready, e_enq, e_din}) begin
        errors++;
        $display("FAIL rst_restart %0d: ready=%b, required ready=%b", c, o_ready, 4'b0001 << c);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   rv = '0;
    logic [N-1:0]   rl = '0;
    logic [N*W-1:0] rd = '0;
    logic           rr;
    for (int c = 0; c < 400; c++) begin
      rr = ($urandom_range(0, 99) == 0);
      apply(rr, rv, rl, ($urandom_range(0, 3) == 0), rd);
      checks++;
      if ({o_ready, o_enq, o_din} !== {e_ready, e_enq, e_din}) begin
        errors++;
        $display("FAIL random cyc %0d: ready=%b enq=%b din=%h, required ready=%b enq=%b din=%h",
                 c, o_ready, o_enq, o_din, e_ready, e_enq, e_din);
      end
      // Offered beats that were not taken stay put; the rest are redrawn.
      for (int i = 0; i < N; i++) begin
        if (!(rv[i] && !e_ready[i])) begin
          rv[i] = ($urandom_range(0, 2) != 0);
          rl[i] = $urandom_range(0, 1);
          rd[i*W +: W] = $urandom;
        end
      end
    end
`ifdef FIFO_ARB_PERF_EN
    for (int i = 0; i < N; i++) begin
      checks++;
      if (perf_g[i*CW +: CW] !== CW'(m_g[i]) || perf_g2[i*2 +: 2] !== 2'(m_g2[i])) begin
        errors++;
        $display("FAIL perf_grant %0d: got %0d/%0d, required %0d/%0d",
                 i, perf_g[i*CW +: CW], perf_g2[i*2 +: 2], m_g[i], m_g2[i]);
      end
    end
    checks++;
    if (perf_s !== CW'(m_s) || perf_s2 !== 2'(m_s2)) begin
      errors++;
      $display("FAIL perf_stall: got %0d/%0d, required %0d/%0d", perf_s, perf_s2, m_s, m_s2);
    end
`endif
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin m_g[i] = 0; m_g2[i] = 0; end
    #1;
    test_reset();
    test_round_robin();
    test_full_stall();
    test_burst();
    test_wrap();
    test_lock_idle();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
